// File: rtl/qr_recon.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : qr_recon
// Brief    : Rebuilds a 2x2 complex channel H = Q*R on one shared complex MAC.
// Revision : 1.0  initial release
// ============================================================================
module qr_recon #(
    parameter int W       = 28,
    parameter int Q_SCALE = 10000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] Q11_real,
    input  logic [W-1:0] Q11_imag,
    input  logic [W-1:0] Q12_real,
    input  logic [W-1:0] Q12_imag,
    input  logic [W-1:0] Q21_real,
    input  logic [W-1:0] Q21_imag,
    input  logic [W-1:0] Q22_real,
    input  logic [W-1:0] Q22_imag,
    input  logic [W-1:0] R11_real,
    input  logic [W-1:0] R12_real,
    input  logic [W-1:0] R12_imag,
    input  logic [W-1:0] R22_real,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] H11_real,
    output logic [W-1:0] H11_imag,
    output logic [W-1:0] H12_real,
    output logic [W-1:0] H12_imag,
    output logic [W-1:0] H21_real,
    output logic [W-1:0] H21_imag,
    output logic [W-1:0] H22_real,
    output logic [W-1:0] H22_imag,
    output logic         ovf
);

    localparam int c_PW = 2 * W;
    localparam int c_AW = 2 * W + 2;
    localparam logic signed [c_AW-1:0] c_QS   = c_AW'(Q_SCALE);
    localparam logic signed [c_AW-1:0] c_HMAX = {{(c_AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [c_AW-1:0] c_HMIN = {{(c_AW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    // Q index order: 0=Q11, 1=Q12, 2=Q21, 3=Q22
    logic signed [W-1:0]    r_q_re [4];
    logic signed [W-1:0]    r_q_im [4];
    logic signed [W-1:0]    r_r11, r_r12_re, r_r12_im, r_r22;
    logic [2:0]             r_step, r_pstep;
    logic                   r_pvld;
    logic signed [c_PW-1:0] r_p_ac, r_p_bd, r_p_ad, r_p_bc;
    // Accumulator / output order: H11r, H11i, H12r, H12i, H21r, H21i, H22r, H22i
    logic signed [c_AW-1:0] r_acc [8];
    logic [W-1:0]           r_h [8];
    logic                   r_ovf;

    logic signed [W-1:0]    w_a, w_b, w_c, w_d;
    logic signed [c_PW-1:0] w_ax, w_bx, w_cx, w_dx;
    logic signed [c_AW-1:0] w_pre, w_pim;
    logic signed [c_AW-1:0] w_acc_nxt [8];
    logic signed [c_AW-1:0] w_quot [8];
    logic [W-1:0]           w_h_sat [8];
    logic [7:0]             w_clip;
    logic                   w_accept, w_issue, w_mac_last;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_mac_last = (r_state == S_MAC) && r_pvld && (r_pstep == 3'd5);
    assign w_issue    = (r_state == S_MAC) && !(r_pvld && (r_pstep == 3'd5));

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_MAC;
            end
            S_MAC: begin
                if (w_mac_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand selection for the shared complex multiplier
    always_comb begin
        w_a = r_q_re[0];
        w_b = r_q_im[0];
        w_c = r_r11;
        w_d = '0;
        case (r_step)
            3'd1: begin w_a = r_q_re[2]; w_b = r_q_im[2]; end
            3'd2: begin w_c = r_r12_re; w_d = r_r12_im; end
            3'd3: begin w_a = r_q_re[1]; w_b = r_q_im[1]; w_c = r_r22; end
            3'd4: begin w_a = r_q_re[2]; w_b = r_q_im[2]; w_c = r_r12_re; w_d = r_r12_im; end
            3'd5: begin w_a = r_q_re[3]; w_b = r_q_im[3]; w_c = r_r22; end
            default: ;
        endcase
    end

    assign w_ax  = {{W{w_a[W-1]}}, w_a};
    assign w_bx  = {{W{w_b[W-1]}}, w_b};
    assign w_cx  = {{W{w_c[W-1]}}, w_c};
    assign w_dx  = {{W{w_d[W-1]}}, w_d};
    assign w_pre = {{2{r_p_ac[c_PW-1]}}, r_p_ac} - {{2{r_p_bd[c_PW-1]}}, r_p_bd};
    assign w_pim = {{2{r_p_ad[c_PW-1]}}, r_p_ad} + {{2{r_p_bc[c_PW-1]}}, r_p_bc};

    // Products lag the issue by one edge; steps 3 and 5 add, the others load
    always_comb begin
        for (int i = 0; i < 8; i++) w_acc_nxt[i] = r_acc[i];
        if (r_pvld) begin
            case (r_pstep)
                3'd0: begin w_acc_nxt[0] = w_pre; w_acc_nxt[1] = w_pim; end
                3'd1: begin w_acc_nxt[4] = w_pre; w_acc_nxt[5] = w_pim; end
                3'd2: begin w_acc_nxt[2] = w_pre; w_acc_nxt[3] = w_pim; end
                3'd3: begin w_acc_nxt[2] = r_acc[2] + w_pre; w_acc_nxt[3] = r_acc[3] + w_pim; end
                3'd4: begin w_acc_nxt[6] = w_pre; w_acc_nxt[7] = w_pim; end
                3'd5: begin w_acc_nxt[6] = r_acc[6] + w_pre; w_acc_nxt[7] = r_acc[7] + w_pim; end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_quot[i]  = w_acc_nxt[i] / c_QS;
            w_h_sat[i] = w_quot[i][W-1:0];
            w_clip[i]  = 1'b0;
            if (w_quot[i] > c_HMAX) begin
                w_h_sat[i] = c_HMAX[W-1:0];
                w_clip[i]  = 1'b1;
            end else if (w_quot[i] < c_HMIN) begin
                w_h_sat[i] = c_HMIN[W-1:0];
                w_clip[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_pstep  <= '0;
            r_pvld   <= 1'b0;
            r_p_ac   <= '0;
            r_p_bd   <= '0;
            r_p_ad   <= '0;
            r_p_bc   <= '0;
            r_ovf    <= 1'b0;
            r_r11    <= '0;
            r_r12_re <= '0;
            r_r12_im <= '0;
            r_r22    <= '0;
            for (int i = 0; i < 4; i++) begin
                r_q_re[i] <= '0;
                r_q_im[i] <= '0;
            end
            for (int i = 0; i < 8; i++) begin
                r_acc[i] <= '0;
                r_h[i]   <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_pvld  <= w_issue;
            if (w_accept) begin
                r_step    <= '0;
                r_q_re[0] <= Q11_real;
                r_q_im[0] <= Q11_imag;
                r_q_re[1] <= Q12_real;
                r_q_im[1] <= Q12_imag;
                r_q_re[2] <= Q21_real;
                r_q_im[2] <= Q21_imag;
                r_q_re[3] <= Q22_real;
                r_q_im[3] <= Q22_imag;
                r_r11     <= R11_real;
                r_r12_re  <= R12_real;
                r_r12_im  <= R12_imag;
                r_r22     <= R22_real;
            end
            if (w_issue) begin
                r_p_ac  <= w_ax * w_cx;
                r_p_bd  <= w_bx * w_dx;
                r_p_ad  <= w_ax * w_dx;
                r_p_bc  <= w_bx * w_cx;
                r_pstep <= r_step;
                if (r_step != 3'd5) r_step <= r_step + 3'd1;
            end
            if (r_state == S_MAC) begin
                for (int i = 0; i < 8; i++) r_acc[i] <= w_acc_nxt[i];
            end
            if (w_mac_last) begin
                for (int i = 0; i < 8; i++) r_h[i] <= w_h_sat[i];
                r_ovf <= |w_clip;
            end
        end
    end

    assign H11_real = r_h[0];
    assign H11_imag = r_h[1];
    assign H12_real = r_h[2];
    assign H12_imag = r_h[3];
    assign H21_real = r_h[4];
    assign H21_imag = r_h[5];
    assign H22_real = r_h[6];
    assign H22_imag = r_h[7];
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_qr_recon.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_qr_recon
// Brief    : Directed vector table, corner sequences and random sets for qr_recon.
// Revision : 1.0  initial release
// ============================================================================
module tb_qr_recon;

    localparam int W  = 28;
    localparam int QS = 10000000;
    localparam longint c_MAX = 134217727;
    localparam longint c_MIN = -134217728;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, in_valid, in_ready, out_valid, out_ready, ovf;
    logic [W-1:0] Q11_real, Q11_imag, Q12_real, Q12_imag, Q21_real, Q21_imag, Q22_real, Q22_imag;
    logic [W-1:0] R11_real, R12_real, R12_imag, R22_real;
    logic [W-1:0] H11_real, H11_imag, H12_real, H12_imag, H21_real, H21_imag, H22_real, H22_imag;

    qr_recon #(.W(W), .Q_SCALE(QS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Q11_real(Q11_real), .Q11_imag(Q11_imag), .Q12_real(Q12_real), .Q12_imag(Q12_imag),
        .Q21_real(Q21_real), .Q21_imag(Q21_imag), .Q22_real(Q22_real), .Q22_imag(Q22_imag),
        .R11_real(R11_real), .R12_real(R12_real), .R12_imag(R12_imag), .R22_real(R22_real),
        .out_valid(out_valid), .out_ready(out_ready),
        .H11_real(H11_real), .H11_imag(H11_imag), .H12_real(H12_real), .H12_imag(H12_imag),
        .H21_real(H21_real), .H21_imag(H21_imag), .H22_real(H22_real), .H22_imag(H22_imag),
        .ovf(ovf)
    );

    // q: Q11r Q11i Q12r Q12i Q21r Q21i Q22r Q22i; r: R11 R12r R12i R22;
    // h: H11r H11i H12r H12i H21r H21i H22r H22i
    typedef struct packed {
        logic [7:0][W-1:0] q;
        logic [3:0][W-1:0] r;
        logic [7:0][W-1:0] h;
        logic              ovf;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0][W-1:0] dut_h();
        return {H22_imag, H22_real, H21_imag, H21_real, H12_imag, H12_real, H11_imag, H11_real};
    endfunction

    task automatic cmp_h(input string tag, input vec_t e);
        logic [7:0][W-1:0] a;
        a = dut_h();
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s H[%0d]", tag, i), longint'($signed(a[i])), longint'($signed(e.h[i])));
        chk({tag, " ovf"}, longint'(ovf), longint'(e.ovf));
    endtask

    function automatic vec_t mkv(input int q0, q1, q2, q3, q4, q5, q6, q7, r0, r1, r2, r3);
        vec_t v;
        v = '0;
        v.q = {W'(q7), W'(q6), W'(q5), W'(q4), W'(q3), W'(q2), W'(q1), W'(q0)};
        v.r = {W'(r3), W'(r2), W'(r1), W'(r0)};
        return v;
    endfunction

    function automatic vec_t seth(input vec_t v, input int h0, h1, h2, h3, h4, h5, h6, h7, input bit o);
        vec_t x;
        x = v;
        x.h = {W'(h7), W'(h6), W'(h5), W'(h4), W'(h3), W'(h2), W'(h1), W'(h0)};
        x.ovf = o;
        return x;
    endfunction

    // Reference: direct complex formula in 64-bit, truncating divide, clamp
    function automatic vec_t model(input vec_t v);
        vec_t   o;
        longint qr[4], qi[4], r11, rr, ri, r22, s[8], d;
        o = v;
        for (int k = 0; k < 4; k++) begin
            qr[k] = longint'($signed(v.q[2*k]));
            qi[k] = longint'($signed(v.q[2*k+1]));
        end
        r11 = longint'($signed(v.r[0]));
        rr  = longint'($signed(v.r[1]));
        ri  = longint'($signed(v.r[2]));
        r22 = longint'($signed(v.r[3]));
        s[0] = qr[0] * r11;
        s[1] = qi[0] * r11;
        s[2] = qr[0] * rr - qi[0] * ri + qr[1] * r22;
        s[3] = qr[0] * ri + qi[0] * rr + qi[1] * r22;
        s[4] = qr[2] * r11;
        s[5] = qi[2] * r11;
        s[6] = qr[2] * rr - qi[2] * ri + qr[3] * r22;
        s[7] = qr[2] * ri + qi[2] * rr + qi[3] * r22;
        o.ovf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d = s[i] / longint'(QS);
            if (d > c_MAX) begin d = c_MAX; o.ovf = 1'b1; end
            if (d < c_MIN) begin d = c_MIN; o.ovf = 1'b1; end
            o.h[i] = W'(d);
        end
        return o;
    endfunction

    task automatic drive(input vec_t v);
        {Q22_imag, Q22_real, Q21_imag, Q21_real, Q12_imag, Q12_real, Q11_imag, Q11_real} = v.q;
        {R22_real, R12_imag, R12_real, R11_real} = v.r;
    endtask

    task automatic garbage();
        vec_t g;
        g.q = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        g.r = {$urandom, $urandom};
        drive(g);
    endtask

    function automatic int rs(input int lim);
        return int'($urandom_range(0, 2 * lim)) - lim;
    endfunction

    // One full transaction: expected pushed at accept, popped when out_valid shows
    task automatic run_set(input vec_t v, input int stall, input bit noise, input string tag);
        vec_t e;
        int   lat;
        @(negedge clk);
        drive(v);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        chk({tag, " in_ready"}, longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(v);
        if (noise) garbage();
        lat = 0;
        while (!out_valid && lat < 30) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                garbage();
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, " latency"}, lat, 7);
        for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            garbage();
            @(posedge clk); #1;
            chk({tag, " stall out_valid"}, longint'(out_valid), 1);
            chk({tag, " stall in_ready"}, longint'(in_ready), 0);
            cmp_h({tag, " stall"}, sb[0]);
        end
        e = sb.pop_front();
        cmp_h(tag, e);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, " post out_valid"}, longint'(out_valid), 0);
        chk({tag, " post in_ready"}, longint'(in_ready), 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, idv;
        int   cnt, mode, lim_q, lim_r;

        idv    = seth(mkv(QS, 0, 0, 0, 0, 0, QS, 0, 5, 3, 2, 4), 5, 0, 3, 2, 0, 0, 4, 0, 1'b0);
        tbl[0] = idv;
        tbl[1] = seth(mkv(-5000000, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0), -1, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        tbl[2] = seth(mkv(134217727, 0, 0, 0, 0, 0, 0, 0, 134217727, 0, 0, 0),
                      134217727, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        tbl[3] = idv;
        tbl[4] = seth(mkv(-134217727, 0, 0, 0, 0, 0, 0, 0, 134217727, 0, 0, 0),
                      -134217728, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        tbl[5] = seth(mkv(0, QS, 0, QS, 0, 0, 0, 0, 7, 1, 0, -2), 0, 7, 0, -1, 0, 0, 0, 0, 1'b0);
        tbl[6] = seth(mkv(0, 0, 0, 0, 5000000, 0, -2500000, 0, -9, 4, -6, 8), 0, 0, 0, 0, -4, 0, 0, -3, 1'b0);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive('0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", longint'(out_valid), 0);
        chk("reset in_ready", longint'(in_ready), 1);
        cmp_h("reset", '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_set(tbl[i], 0, 1'b0, $sformatf("table%0d", i));

        run_set(idv, 20, 1'b1, "backpressure");

        // Abort after three multiplier steps; nothing may come out for that set
        @(negedge clk);
        drive(tbl[2]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort out_valid", longint'(out_valid), 0);
        chk("abort in_ready", longint'(in_ready), 1);
        cmp_h("abort", '0);
        cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        chk("abort no result", cnt, 0);
        run_set(idv, 0, 1'b0, "after_abort");

        for (int i = 0; i < 2000; i++) begin
            mode  = $urandom_range(0, 2);
            lim_q = (mode == 2) ? 134217727 : QS;
            lim_r = (mode == 0) ? 1000 : ((mode == 1) ? 1048576 : 134217727);
            v = mkv(rs(lim_q), rs(lim_q), rs(lim_q), rs(lim_q), rs(lim_q), rs(lim_q), rs(lim_q),
                    rs(lim_q), rs(lim_r), rs(lim_r), rs(lim_r), rs(lim_r));
            v = model(v);
            run_set(v, (i % 97 == 0) ? 2 : 0, (i % 5 == 0), $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
